// File: rtl/bus_resp_pkg.sv
// Shared types and constants for the bus register responder and its address decoder.
package bus_resp_pkg;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } state_t;

  localparam int ADDR_LSB  = 2;
  localparam int ERR_CNT_W = 16;
  // Wide enough for index 64, the error-counter slot of a 64-register build.
  localparam int IDX_W     = 7;

  typedef struct packed {
    logic             ok;
    logic [IDX_W-1:0] index;
  } decode_t;

endpackage

// File: rtl/bus_resp_decode.sv
// Combinational decode of a held bus address into a register index and an ok flag.
// With BUS_RESP_ERR_CNT_EN defined, index NUM_REGS (the error counter) is mapped.
module bus_resp_decode
  import bus_resp_pkg::*;
#(
  parameter int          NUM_REGS  = 8,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
  input  logic [31:0] addr,
  input  logic        rnw,
  output decode_t     dec
);

`ifdef BUS_RESP_ERR_CNT_EN
  localparam int LAST_IDX = NUM_REGS;
`else
  localparam int LAST_IDX = NUM_REGS - 1;
`endif

  logic [31:0]          offset;
  logic [31-ADDR_LSB:0] word;
  logic                 aligned;
  logic                 in_range;
  logic                 ro_write;

  // BASE_ADDR is aligned, so the offset's low bits equal addr's; an address
  // below BASE_ADDR wraps to a huge word index and falls out of range.
  always_comb begin
    offset   = addr - BASE_ADDR;
    word     = offset[31:ADDR_LSB];
    aligned  = (offset[ADDR_LSB-1:0] == '0);
    in_range = (word <= (32 - ADDR_LSB)'(LAST_IDX));
    ro_write = !rnw && (word == '0);
    dec.ok    = aligned && in_range && !ro_write;
    dec.index = word[IDX_W-1:0];
  end

endmodule

// File: rtl/bus_reg_responder.sv
// Register-file responder on the valid/ready bus with configurable wait states.
// Optional feature macro: BUS_RESP_ERR_CNT_EN (saturating errored-access counter).
//
// Handshake: the initiator raises valid with addr/write_data/rnw stable and holds
// them until ready; ready is a one-cycle strobe that completes the transfer, and
// read_data/error are meaningful only in that cycle (0 otherwise).
module bus_reg_responder
  import bus_resp_pkg::*;
#(
  parameter int          NUM_REGS    = 8,
  parameter int          WAIT_STATES = 1,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter logic [31:0] ID_VALUE    = 32'h0B05_0001
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [31:0]              addr,
  input  logic [31:0]              write_data,
  input  logic                     rnw,
  input  logic                     valid,
  output logic                     ready,
  output logic [31:0]              read_data,
  output logic                     error,
  output logic [NUM_REGS*32-1:0]   reg_out
`ifdef BUS_RESP_ERR_CNT_EN
  ,
  output logic [ERR_CNT_W-1:0]     err_count
`endif
);

  state_t           state;
  logic [3:0]       wait_cnt;
  logic [31:0]      regs [NUM_REGS];
  decode_t          dec;
  logic             enter_resp;
  logic [31:0]      rd_mux;
  logic             wr_pend;
  logic [IDX_W-1:0] wr_index;
  logic [31:0]      wr_data;

`ifdef BUS_RESP_ERR_CNT_EN
  logic [ERR_CNT_W-1:0] err_cnt;
  assign err_count = err_cnt;
`endif

  bus_resp_decode #(
    .NUM_REGS  (NUM_REGS),
    .BASE_ADDR (BASE_ADDR)
  ) u_decode (
    .addr (addr),
    .rnw  (rnw),
    .dec  (dec)
  );

  always_comb begin
    rd_mux = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (dec.index == IDX_W'(i)) rd_mux = regs[i];
    end
`ifdef BUS_RESP_ERR_CNT_EN
    if (dec.index == IDX_W'(NUM_REGS)) rd_mux = {{(32-ERR_CNT_W){1'b0}}, err_cnt};
`endif
  end

  // The response is captured on the edge that moves into RESP, and only if the
  // initiator is still holding valid at that edge.
  assign enter_resp = valid &&
                      (((state == IDLE) && (WAIT_STATES == 0)) ||
                       ((state == WAIT) && (wait_cnt == 4'(WAIT_STATES - 1))));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      wait_cnt  <= '0;
      ready     <= 1'b0;
      read_data <= '0;
      error     <= 1'b0;
      wr_pend   <= 1'b0;
      wr_index  <= '0;
      wr_data   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (valid) begin
            state    <= (WAIT_STATES == 0) ? RESP : WAIT;
            wait_cnt <= '0;
          end
        end
        WAIT: begin
          if (!valid) begin
            state    <= IDLE;
            wait_cnt <= '0;
          end else if (enter_resp) begin
            state    <= RESP;
            wait_cnt <= '0;
          end else begin
            wait_cnt <= wait_cnt + 4'd1;
          end
        end
        RESP: begin
          state     <= IDLE;
          ready     <= 1'b0;
          read_data <= '0;
          error     <= 1'b0;
          wr_pend   <= 1'b0;
        end
        default: state <= IDLE;
      endcase

      if (enter_resp) begin
        ready     <= 1'b1;
        error     <= !dec.ok;
        read_data <= (rnw && dec.ok) ? rd_mux : '0;
        wr_pend   <= !rnw && dec.ok;
        wr_index  <= dec.index;
        wr_data   <= write_data;
      end
    end
  end

  // Register 0 is never written because the decoder rejects writes to it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      regs[0] <= ID_VALUE;
      for (int i = 1; i < NUM_REGS; i++) regs[i] <= '0;
    end else if ((state == RESP) && wr_pend) begin
      for (int i = 1; i < NUM_REGS; i++) begin
        if (wr_index == IDX_W'(i)) regs[i] <= wr_data;
      end
    end
  end

`ifdef BUS_RESP_ERR_CNT_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      err_cnt <= '0;
    end else if (state == RESP) begin
      if (error) begin
        if (err_cnt != '1) err_cnt <= err_cnt + 1'b1;
      end else if (wr_pend && (wr_index == IDX_W'(NUM_REGS))) begin
        err_cnt <= '0;
      end
    end
  end
`endif

  for (genvar g = 0; g < NUM_REGS; g++) begin : g_reg_out
    assign reg_out[32*g +: 32] = regs[g];
  end

endmodule
